// File: rtl/fifo_port_arbiter.sv
// Sequencer between NREQ producers, one consumer and a single manual-mode FIFO.
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   p_valid/p_data       producer offers; p_ready is the one-hot round-robin grant
//   c_valid/c_data       consumer output stage, handshaken by c_ready
//   fifo_RST/wReq/rReq   registered FIFO controls; fifo_din registered write data
//   fifo_auto            tied low (manual mode)
//   fifo_dout/fifo_error FIFO read data and error flag
//   count                words committed to the FIFO (issued writes minus issued reads)
//   last_grant           most recently granted producer
//   err                  sticky protocol-fault flag
module fifo_port_arbiter #(
    parameter int unsigned WL    = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NREQ  = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned GW   = $clog2(NREQ)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    p_valid,
    input  logic [NREQ*WL-1:0] p_data,
    output logic [NREQ-1:0]    p_ready,
    output logic               c_valid,
    output logic [WL-1:0]      c_data,
    input  logic               c_ready,
    output logic               fifo_RST,
    output logic               fifo_wReq,
    output logic               fifo_rReq,
    output logic [WL-1:0]      fifo_din,
    output logic               fifo_auto,
    input  logic [WL-1:0]      fifo_dout,
    input  logic               fifo_error,
    output logic [CW-1:0]      count,
    output logic [GW-1:0]      last_grant,
    output logic               err
);

    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_CAP, RD_OUT} rd_state_t;

    rd_state_t         rd_state, rd_next;
    logic              rreq_next, cvalid_next, rd_fire;
    logic [WL-1:0]     cdata_next;
    logic              wr_allow, wr_fire;
    logic [NREQ-1:0]   grant;
    logic [GW-1:0]     grant_idx, cand_idx;
    int unsigned       cand;
    logic              req_prev;

    assign fifo_auto = 1'b0;
    assign p_ready   = grant;

    // Writes are blocked while the FIFO is being reset or is full by our own accounting.
    assign wr_allow = !fifo_RST && (count < CW'(DEPTH));

    // Round-robin search starting just after the last granted producer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        wr_fire   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        if (wr_allow) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand     = (32'(last_grant) + k) % NREQ;
                cand_idx = GW'(cand);
                if (!wr_fire && p_valid[cand_idx]) begin
                    wr_fire         = 1'b1;
                    grant[cand_idx] = 1'b1;
                    grant_idx       = cand_idx;
                end
            end
        end
    end

    // Read sequencing: request, wait for registered dout, capture, hold until accepted.
    always_comb begin
        rd_next     = rd_state;
        rreq_next   = 1'b0;
        cvalid_next = c_valid;
        cdata_next  = c_data;
        rd_fire     = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (!fifo_RST && (count != '0)) begin
                    rd_fire   = 1'b1;
                    rreq_next = 1'b1;
                    rd_next   = RD_REQ;
                end
            end
            RD_REQ:  rd_next = RD_CAP;
            RD_CAP: begin
                cdata_next  = fifo_dout;
                cvalid_next = 1'b1;
                rd_next     = RD_OUT;
            end
            RD_OUT: begin
                if (c_ready) begin
                    cvalid_next = 1'b0;
                    rd_next     = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read state register and consumer output stage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_state  <= RD_IDLE;
            fifo_rReq <= 1'b0;
            c_valid   <= 1'b0;
            c_data    <= '0;
        end else begin
            rd_state  <= rd_next;
            fifo_rReq <= rreq_next;
            c_valid   <= cvalid_next;
            c_data    <= cdata_next;
        end
    end

    // FIFO reset is held for exactly one cycle after RST_N releases.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_RST <= 1'b1;
        end else begin
            fifo_RST <= 1'b0;
        end
    end

    // Write issue, occupancy accounting and grant history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_wReq  <= 1'b0;
            fifo_din   <= '0;
            last_grant <= GW'(NREQ - 1);
            count      <= '0;
        end else begin
            fifo_wReq <= wr_fire;
            if (wr_fire) begin
                fifo_din   <= p_data[grant_idx*WL +: WL];
                last_grant <= grant_idx;
            end
            count <= count + CW'(wr_fire) - CW'(rd_fire);
        end
    end

    // An error flag seen the cycle after a request reached the FIFO is latched.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_prev <= 1'b0;
            err      <= 1'b0;
        end else begin
            req_prev <= fifo_wReq | fifo_rReq;
            err      <= err | (req_prev & fifo_error);
        end
    end

endmodule
